// File: rtl/gauss_array_seq_pkg.sv
// gauss_array_seq_pkg: op-codes, gauss_op codes and state encoding for the column sequencer
package gauss_array_seq_pkg;
  typedef logic [1:0] gop_t;
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_GAUSS = 4'd1;
  localparam logic [3:0] OP_KEY   = 4'd3;
  localparam logic [3:0] OP_LDB   = 4'd4;
  localparam logic [3:0] OP_SHB   = 4'd5;
  localparam logic [3:0] OP_MAC   = 4'd6;
  localparam logic [3:0] OP_MACK  = 4'd7;
  localparam gop_t G_PASS = 2'b00;
  localparam gop_t G_MUL  = 2'b01;
  localparam gop_t G_ADD  = 2'b10;
  localparam gop_t G_OUT  = 2'b11;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KEY   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_MAC   = 3'd3;
  localparam logic [2:0] S_GAUSS = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
endpackage

// File: rtl/gauss_array_seq_if.sv
// gauss_array_seq_if: command, row-beat and column-head signals of the sequencer
interface gauss_array_seq_if #(
  parameter int GF_BIT = 4,
  parameter int OP_CODE_LEN = 4,
  parameter int LEN_W = 6
);
  logic cmd_valid;
  logic cmd_ready;
  logic [OP_CODE_LEN-1:0] cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic row_valid;
  logic row_ready;
  logic [GF_BIT-1:0] row_data;
  logic pe_start;
  logic [OP_CODE_LEN-1:0] pe_op;
  logic [1:0] pe_gauss_op;
  logic [GF_BIT-1:0] pe_data;
  modport master (
    output cmd_valid, cmd_op, cmd_len, row_valid, row_data,
    input  cmd_ready, row_ready, pe_start, pe_op, pe_gauss_op, pe_data
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_len, row_valid, row_data,
    output cmd_ready, row_ready, pe_start, pe_op, pe_gauss_op, pe_data
  );
endinterface

// File: rtl/gauss_array_seq_cnt2d.sv
// seq_cnt2d: beat counter b wrapping at len-1 into pass counter p
module seq_cnt2d #(
  parameter int LEN_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] b,
  output logic [LEN_W-1:0] p,
  output logic last_beat,
  output logic last_all
);
  logic [LEN_W-1:0] lm1;
  assign lm1 = len - LEN_W'(1);
  assign last_beat = b == lm1;
  assign last_all = last_beat && p == lm1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b <= '0;
      p <= '0;
    end else if (clear) begin
      b <= '0;
      p <= '0;
    end else if (en) begin
      b <= last_beat ? '0 : b + LEN_W'(1);
      p <= last_beat ? p + LEN_W'(1) : p;
    end
  end
endmodule

// File: rtl/gauss_array_seq.sv
// gauss_array_seq: schedules load/MAC/key/Gaussian passes onto the PE column head,
// then drains the column pipeline and pulses done.
module gauss_array_seq
  import gauss_array_seq_pkg::*;
#(
  parameter int GF_BIT = 4,
  parameter int OP_CODE_LEN = 4,
  parameter int LEN_W = 6,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  gauss_array_seq_if.slave bus,
  output logic busy,
  output logic done,
  output logic cmd_err
);
  localparam int DW = $clog2(DEPTH + 1);
  logic [2:0] state, nxt, disp;
  logic [OP_CODE_LEN-1:0] op_q;
  logic [LEN_W-1:0] len_q, b, unused_p;
  logic [DW-1:0] d;
  logic accept, beat, op_ok, last_beat, last_all;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign bus.row_ready = state == S_LOAD || state == S_MAC || state == S_GAUSS;
  assign beat = bus.row_valid && bus.row_ready;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign op_ok = bus.cmd_op == OP_CODE_LEN'(OP_GAUSS) || bus.cmd_op == OP_CODE_LEN'(OP_KEY)
              || bus.cmd_op == OP_CODE_LEN'(OP_LDB) || bus.cmd_op == OP_CODE_LEN'(OP_MAC)
              || bus.cmd_op == OP_CODE_LEN'(OP_MACK);
  assign disp = (!op_ok || bus.cmd_len == '0) ? S_DONE
              : bus.cmd_op == OP_CODE_LEN'(OP_KEY) ? S_KEY
              : bus.cmd_op == OP_CODE_LEN'(OP_LDB) ? S_LOAD
              : bus.cmd_op == OP_CODE_LEN'(OP_GAUSS) ? S_GAUSS : S_MAC;
  seq_cnt2d #(.LEN_W(LEN_W)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .en(beat),
    .clear(state == S_IDLE),
    .len(len_q),
    .b(b),
    .p(unused_p),
    .last_beat(last_beat),
    .last_all(last_all)
  );
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:          nxt = accept ? disp : S_IDLE;
      S_KEY:           nxt = S_DRAIN;
      S_LOAD, S_MAC:   nxt = (beat && last_beat) ? S_DRAIN : state;
      S_GAUSS:         nxt = (beat && last_all) ? S_DRAIN : state;
      S_DRAIN:         nxt = (d == DW'(DEPTH - 1)) ? S_DONE : S_DRAIN;
      default:         nxt = S_IDLE;
    endcase
  end
  // Cycles without a beat register a NOP so the PEs hold their r values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      bus.cmd_ready <= 1'b0;
      cmd_err <= 1'b0;
      op_q <= '0;
      len_q <= '0;
      d <= '0;
      bus.pe_start <= 1'b0;
      bus.pe_op <= '0;
      bus.pe_gauss_op <= G_PASS;
      bus.pe_data <= '0;
    end else begin
      state <= nxt;
      bus.cmd_ready <= nxt == S_IDLE;
      cmd_err <= accept && !op_ok;
      op_q <= accept ? bus.cmd_op : op_q;
      len_q <= accept ? bus.cmd_len : len_q;
      d <= state == S_DRAIN ? d + DW'(1) : '0;
      bus.pe_start <= beat && state == S_GAUSS && b == '0;
      bus.pe_op <= beat ? op_q : state == S_KEY ? OP_CODE_LEN'(OP_KEY) : '0;
      bus.pe_gauss_op <= !(beat && state == S_GAUSS) ? G_PASS : b == '0 ? G_MUL : G_ADD;
      bus.pe_data <= beat ? bus.row_data : '0;
    end
  end
endmodule

// File: tb/tb_gauss_array_seq.sv
// tb_gauss_array_seq: directed scenarios for the column sequencer
module tb_gauss_array_seq;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done, cmd_err;
  int checks = 0;
  int failures = 0;

  gauss_array_seq_if #(.GF_BIT(4), .OP_CODE_LEN(4), .LEN_W(6)) bus ();
  gauss_array_seq #(.GF_BIT(4), .OP_CODE_LEN(4), .LEN_W(6), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .busy(busy),
    .done(done),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [5:0] len);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_len = len;
    tick;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_len = 0; bus.row_valid = 0; bus.row_data = 0;
    rst_n = 1'b0;
    tick; tick;
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", bus.cmd_ready); end
    checks++; if ({bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data} !== 11'h0) begin failures++; $display("FAIL reset_pe got=%h exp=0", {bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data}); end
    checks++; if ({busy, done, cmd_err} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", {busy, done, cmd_err}); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL release_cmd_ready_early got=%b exp=0", bus.cmd_ready); end
    tick;
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL release_cmd_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_load;
    issue(4'd4, 6'd3);
    checks++; if ({bus.row_ready, busy, bus.cmd_ready} !== 3'b110) begin failures++; $display("FAIL load_accept got=%b exp=110", {bus.row_ready, busy, bus.cmd_ready}); end
    for (int i = 0; i < 3; i++) begin
      bus.row_valid = 1'b1;
      bus.row_data = 4'(5 + i);
      tick;
      checks++; if ({bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data} !== {1'b0, 2'b00, 4'd4, 4'(5 + i)}) begin failures++; $display("FAIL load_beat%0d got=%h exp=%h", i, {bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data}, {1'b0, 2'b00, 4'd4, 4'(5 + i)}); end
    end
    bus.row_valid = 1'b0;
    checks++; if (bus.row_ready !== 1'b0) begin failures++; $display("FAIL load_drain_row_ready got=%b exp=0", bus.row_ready); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL load_early_done cycle=%0d got=%b exp=0", i, done); end
      if (i >= 2) begin
        checks++; if ({bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data} !== 11'h0) begin failures++; $display("FAIL load_drain_nop cycle=%0d got=%h exp=0", i, {bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data}); end
      end
      tick;
    end
    checks++; if ({done, cmd_err, bus.cmd_ready} !== 3'b100) begin failures++; $display("FAIL load_done got=%b exp=100", {done, cmd_err, bus.cmd_ready}); end
    tick;
    checks++; if ({done, busy, bus.cmd_ready} !== 3'b001) begin failures++; $display("FAIL load_idle got=%b exp=001", {done, busy, bus.cmd_ready}); end
  endtask

  task automatic test_key;
    issue(4'd3, 6'd1);
    checks++; if ({bus.row_ready, bus.pe_op} !== 5'h0) begin failures++; $display("FAIL key_first got=%h exp=0", {bus.row_ready, bus.pe_op}); end
    tick;
    checks++; if ({bus.pe_op, bus.pe_data, bus.row_ready} !== {4'd3, 4'd0, 1'b0}) begin failures++; $display("FAIL key_op got=%h exp=%h", {bus.pe_op, bus.pe_data, bus.row_ready}, {4'd3, 4'd0, 1'b0}); end
    tick;
    checks++; if (bus.pe_op !== 4'd0) begin failures++; $display("FAIL key_nop got=%0d exp=0", bus.pe_op); end
    for (int i = 0; i < DEPTH - 1; i++) begin
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL key_early_done cycle=%0d got=%b exp=0", i, done); end
      tick;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL key_done got=%b exp=1", done); end
    tick;
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL key_idle got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_gauss;
    logic [3:0] es;
    logic [7:0] eg;
    es = 4'b0101;
    eg = 8'b10_01_10_01;
    issue(4'd1, 6'd2);
    for (int i = 0; i < 4; i++) begin
      bus.row_valid = 1'b1;
      bus.row_data = 4'(i + 1);
      tick;
      checks++; if ({bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data} !== {es[i], eg[2*i +: 2], 4'd1, 4'(i + 1)}) begin failures++; $display("FAIL gauss_beat%0d got=%h exp=%h", i, {bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data}, {es[i], eg[2*i +: 2], 4'd1, 4'(i + 1)}); end
    end
    bus.row_valid = 1'b0;
    checks++; if ({bus.row_ready, busy} !== 2'b01) begin failures++; $display("FAIL gauss_drain got=%b exp=01", {bus.row_ready, busy}); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL gauss_early_done cycle=%0d got=%b exp=0", i, done); end
      tick;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL gauss_done got=%b exp=1", done); end
    tick;
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL gauss_idle got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_mac_bubble;
    logic [6:0] vv;
    logic [3:0] dd [7];
    int beats;
    vv = 7'b1110001;
    dd = '{4'd9, 4'd15, 4'd15, 4'd15, 4'd10, 4'd11, 4'd12};
    beats = 0;
    issue(4'd7, 6'd4);
    for (int i = 0; i < 7; i++) begin
      bus.row_valid = vv[i];
      bus.row_data = dd[i];
      tick;
      checks++; if ({bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data} !== (vv[i] ? {1'b0, 2'b00, 4'd7, dd[i]} : 11'h0)) begin failures++; $display("FAIL mac_cycle%0d got=%h exp=%h", i, {bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data}, (vv[i] ? {1'b0, 2'b00, 4'd7, dd[i]} : 11'h0)); end
      if (bus.pe_op == 4'd7) beats++;
    end
    bus.row_valid = 1'b0;
    checks++; if (beats != 4) begin failures++; $display("FAIL mac_beat_count got=%0d exp=4", beats); end
    checks++; if (bus.row_ready !== 1'b0) begin failures++; $display("FAIL mac_drain got=%b exp=0", bus.row_ready); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mac_early_done cycle=%0d got=%b exp=0", i, done); end
      tick;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL mac_done got=%b exp=1", done); end
    tick;
  endtask

  task automatic test_err_and_zero;
    issue(4'd2, 6'd3);
    checks++; if ({cmd_err, done, bus.row_ready} !== 3'b110) begin failures++; $display("FAIL err_pulse got=%b exp=110", {cmd_err, done, bus.row_ready}); end
    tick;
    checks++; if ({cmd_err, done, bus.cmd_ready, bus.pe_op} !== {3'b001, 4'd0}) begin failures++; $display("FAIL err_after got=%h exp=%h", {cmd_err, done, bus.cmd_ready, bus.pe_op}, {3'b001, 4'd0}); end
    issue(4'd4, 6'd0);
    checks++; if ({cmd_err, done, bus.row_ready} !== 3'b010) begin failures++; $display("FAIL zero_len got=%b exp=010", {cmd_err, done, bus.row_ready}); end
    tick;
    checks++; if ({done, bus.cmd_ready} !== 2'b01) begin failures++; $display("FAIL zero_len_idle got=%b exp=01", {done, bus.cmd_ready}); end
  endtask

  task automatic test_reset_mid;
    issue(4'd1, 6'd3);
    for (int i = 0; i < 4; i++) begin
      bus.row_valid = 1'b1;
      bus.row_data = 4'(i + 1);
      tick;
    end
    checks++; if ({bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data} !== {1'b1, 2'b01, 4'd1, 4'd4}) begin failures++; $display("FAIL mid_pass1 got=%h exp=%h", {bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data}, {1'b1, 2'b01, 4'd1, 4'd4}); end
    rst_n = 1'b0;
    bus.row_valid = 1'b0;
    #1;
    checks++; if ({bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data} !== 11'h0) begin failures++; $display("FAIL mid_async_clear got=%h exp=0", {bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data}); end
    checks++; if ({busy, done, bus.cmd_ready} !== 3'b000) begin failures++; $display("FAIL mid_status got=%b exp=000", {busy, done, bus.cmd_ready}); end
    tick; tick;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_no_done got=%b exp=0", done); end
    rst_n = 1'b1;
    tick;
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", bus.cmd_ready); end
    issue(4'd4, 6'd1);
    bus.row_valid = 1'b1;
    bus.row_data = 4'd10;
    tick;
    bus.row_valid = 1'b0;
    checks++; if ({bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data} !== {1'b0, 2'b00, 4'd4, 4'd10}) begin failures++; $display("FAIL mid_load got=%h exp=%h", {bus.pe_start, bus.pe_gauss_op, bus.pe_op, bus.pe_data}, {1'b0, 2'b00, 4'd4, 4'd10}); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_load_early_done cycle=%0d got=%b exp=0", i, done); end
      tick;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL mid_load_done got=%b exp=1", done); end
    tick;
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_load_idle got=%b exp=1", bus.cmd_ready); end
  endtask

  initial begin
    test_reset;
    test_load;
    test_key;
    test_gauss;
    test_mac_bubble;
    test_err_and_zero;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gauss_array_seq.md
# gauss_array_seq

Sequencer for the systolic Gaussian-elimination / MAC column built from the BC processing elements. It accepts one command at a time and consumes row beats from an upstream source. It drives the column-head control (start, op, gauss_op) and data with the per-cycle schedule for load, MAC, key-load and Gaussian-elimination passes. It then flushes the pipeline and signals completion.

## Interface
- GF_BIT, 4: field element width (4 or 8).
- OP_CODE_LEN, 4: PE op-code width.
- LEN_W, 6: width of command length; max n = 2^LEN_W-1.
- DEPTH, 16: drain cycles after the last beat (column pipeline depth).
- clk  in  1  single clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  registered; high only in IDLE.
- cmd_op  in  OP_CODE_LEN  requested PE op (1, 3, 4, 6, 7).
- cmd_len  in  LEN_W  n = row count / matrix dimension.
- row_valid  in  1  row beat offered.
- row_ready  out  1  combinational; high in LOAD, MAC, GAUSS states.
- row_data  in  GF_BIT  row element.
- pe_start  out  1  registered column-head start.
- pe_op  out  OP_CODE_LEN  registered column-head op.
- pe_gauss_op  out  2  registered column-head gauss_op.
- pe_data  out  GF_BIT  registered column-head data_in/dataB_in.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at command completion.
- cmd_err  out  1  one-cycle pulse for unsupported cmd_op.

## Operation
- States: IDLE, KEY, LOAD, MAC, GAUSS, DRAIN, DONE.
- Command handshake: a command is accepted on cmd_valid && cmd_ready. The op and len are latched, and cmd_ready drops on the next edge.
- Dispatch from IDLE:
  - op 3 → KEY
  - op 4 → LOAD
  - op 6/7 → MAC
  - op 1 → GAUSS
  - any other op → DONE with cmd_err=1
  - len 0 with any valid op → DONE; no beats, no drain.
- Beat: row_valid && row_ready. On that edge the outputs are loaded:
  - pe_data ← row_data
  - pe_op ← latched op
  - pe_gauss_op / pe_start ← as given per state below.
- Bubble: any cycle in a beat state without a beat registers NOP: pe_op=0, pe_gauss_op=00, pe_start=0, pe_data=0. The PEs hold r; the schedule position does not advance.
- KEY: one cycle with pe_op=3, no row consumed; then DRAIN.
- LOAD: n beats, pe_op=4, gauss_op=00.
- MAC: n beats, pe_op=latched 6/7, gauss_op=00 (accumulate into r).
- GAUSS: n passes × n beats, counted by pass counter p and beat counter b.
  - b==0: pe_start=1, gauss_op=01 (pivot normalise).
  - b>0: pe_start=0, gauss_op=10 (eliminate).
  - b wraps to 0 at n-1 and p increments; after p==n-1, b==n-1 the state moves to DRAIN.
- DRAIN: DEPTH cycles of NOP outputs, then DONE.
- DONE: done=1 for one cycle, then IDLE with cmd_ready=1 on the following cycle.
- cmd_valid while busy is ignored (not latched).

## Timing
- Reset values: cmd_ready=0, all pe_* = 0, busy=0, done=0, cmd_err=0, counters 0, state IDLE.
- cmd_ready rises on the first clk edge after rst_n deasserts.
- Latency:
  - Command accepted at edge T → row_ready high from cycle T+1.
  - A beat at edge E is visible on pe_* in cycle E+1 (one register stage).
- Completion: last beat at edge E → DRAIN occupies E+1..E+DEPTH → done high in cycle E+DEPTH+1 → cmd_ready high in cycle E+DEPTH+2.
- Counter width: b and p are LEN_W bits. The wrap compare is against len-1, so n = 2^LEN_W-1 is the maximum and there is no overflow.
- Reset mid-command: the command is aborted immediately. Outputs return to reset values asynchronously, and no done pulse is issued.

## Structure
- The shared define header holds:
  - op-code constants OP_NOP=0, OP_GAUSS=1, OP_KEY=3, OP_LDB=4, OP_SHB=5, OP_MAC=6, OP_MACK=7
  - gauss_op constants G_PASS=00, G_MUL=01, G_ADD=10, G_OUT=11
  - state encoding.
- One sub-module, seq_cnt2d, implements the beat/pass counter pair. Interface: en, len, clear, b, p, last_beat, last_all.

## Test plan
- Reset, then release → cmd_ready=0 in the first cycle and 1 after one edge; all pe_* = 0.
- LOAD n=3, row_valid held high, data 5,6,7 → pe_op=4 with pe_data 5,6,7 on consecutive cycles. Then DEPTH NOP cycles, then a done pulse exactly 1+DEPTH cycles after the last beat.
- GAUSS n=2, continuous rows → (start, gauss_op) sequence is (1,01), (0,10), (1,01), (0,10) with pe_op=1; then drain and done.
- MAC op 7 n=4 with row_valid low on beat 2 for 3 cycles → 3 NOP cycles inserted; exactly 4 op-7 beats issued, in order.
- cmd_op=2 → cmd_err and done pulse together one cycle after accept, no beats. Separately, cmd_len=0 with op 4 → done, no row_ready.
- rst_n asserted during GAUSS pass 1 → pe_* clear immediately, no done pulse; a new LOAD n=1 after release completes normally.
